mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MUL_CYCLES, default 5: busy duration of MULT/MULTU, legal range 1..31.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of DIV/DIVU, legal range 1..31.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
REQ-005 start  input  1  issue strobe, qualified by mdop.
REQ-006 mdop  input  3  0=NONE, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO, 7=NONE.
REQ-007 a  input  32  operand A, rs value from GRF RD1.
REQ-008 b  input  32  operand B, rt value from GRF RD2.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse on the cycle after HI/LO take a mult/div result.
REQ-011 hi  output  32  HI register, driven directly from a flop.
REQ-012 lo  output  32  LO register, driven directly from a flop.

Function
REQ-013 FSM SHALL have two states: IDLE and BUSY.
REQ-014 start with mdop 1..4, sampled in IDLE at edge T, SHALL latch a, b, mdop, SHALL load the counter with N (MUL_CYCLES or DIV_CYCLES), and SHALL enter BUSY.
REQ-015 busy SHALL be 1 in the cycles after edges T through T+N-1 and 0 after edge T+N.
REQ-016 At edge T+N the block SHALL write hi/lo, return to IDLE, and set done=1 for exactly the following cycle.
REQ-017 Counter SHALL decrement by 1 per edge in BUSY; the transition to IDLE SHALL occur when the counter reads 1.
REQ-018 MULT SHALL write the signed 64-bit product {hi,lo}=$signed(a)*$signed(b); MULTU SHALL write the unsigned product.
REQ-019 DIV SHALL write lo=signed quotient truncated toward zero, hi=remainder with the sign of a; DIVU SHALL write unsigned quotient and remainder.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-021 MTHI/MTLO with start in IDLE SHALL write a into hi/lo at that edge, leave busy at 0, and leave done at 0.
REQ-022 Any start while BUSY SHALL be ignored: no latch, no HI/LO write, no counter change.
REQ-023 Operands SHALL be the latched copies; changes on a/b during BUSY SHALL have no effect.
REQ-024 mdop 0 or 7 with start SHALL do nothing.
REQ-025 hi/lo SHALL be unchanged at every edge except those named in REQ-016 and REQ-021.

Reset
REQ-026 reset=0 SHALL immediately, without a clock edge, force IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
REQ-027 Reset during BUSY SHALL abort the operation; no result SHALL be written afterwards.
REQ-028 The first edge after reset releases SHALL accept start normally.

Configuration
REQ-029 Macro MDU_DIV0_KEEP_EN selects the divide-by-zero behaviour (b=0 for DIV/DIVU); timing is identical in both cases: busy runs DIV_CYCLES and done pulses.
REQ-030 With MDU_DIV0_KEEP_EN defined: divide-by-zero SHALL leave hi and lo unchanged.
REQ-031 Without MDU_DIV0_KEEP_EN: divide-by-zero SHALL write lo=0xFFFFFFFF, hi=a.

Verification
REQ-032 MULT, a=0xFFFFFFFE, b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses one cycle.
REQ-033 MULTU, a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-034 DIV, a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; a DIVU issued during busy is ignored.
REQ-035 MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive edges -> hi and lo update on those edges; busy and done stay 0.
REQ-036 DIVU, b=0, a=5 -> with macro: hi/lo keep their prior values; without macro: hi=5, lo=0xFFFFFFFF; busy lasts 10 cycles in both builds.
REQ-037 Start MULT, drive reset=0 asynchronously at busy cycle 3 -> busy/hi/lo become 0 before the next edge; no done pulse; a DIVU 20/3 issued after release gives lo=6, hi=2.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers and a fixed-latency busy window.
// Build option MDU_DIV0_KEEP_EN: divide-by-zero leaves HI/LO untouched instead of writing a=>HI, all-ones=>LO.
module mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state, state_next;
  logic [4:0]  count, count_next;
  logic [2:0]  op, op_next;
  logic [31:0] a_lat, a_lat_next;
  logic [31:0] b_lat, b_lat_next;
  logic [31:0] hi_next, lo_next;
  logic        done_next;

  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, div_u_den, div_s_den;
  logic [31:0] quot_u, rem_u, quot_m, rem_m, quot_s, rem_s;
  logic        div_zero;
  logic        res_write;
  logic [31:0] res_hi, res_lo;

  // Signed product as the low 64 bits of a sign-extended 64x64 multiply.
  assign prod_u = {32'd0, a_lat} * {32'd0, b_lat};
  assign prod_s = {{32{a_lat[31]}}, a_lat} * {{32{b_lat[31]}}, b_lat};

  // Signed divide via magnitudes keeps the INT_MIN / -1 case well defined (wraps to INT_MIN).
  assign div_zero  = (b_lat == 32'd0);
  assign mag_a     = a_lat[31] ? (32'd0 - a_lat) : a_lat;
  assign mag_b     = b_lat[31] ? (32'd0 - b_lat) : b_lat;
  assign div_u_den = div_zero ? 32'd1 : b_lat;
  assign div_s_den = div_zero ? 32'd1 : mag_b;
  assign quot_u    = a_lat / div_u_den;
  assign rem_u     = a_lat % div_u_den;
  assign quot_m    = mag_a / div_s_den;
  assign rem_m     = mag_a % div_s_den;
  assign quot_s    = (a_lat[31] ^ b_lat[31]) ? (32'd0 - quot_m) : quot_m;
  assign rem_s     = a_lat[31] ? (32'd0 - rem_m) : rem_m;

  always_comb begin
    res_write = 1'b1;
    res_hi    = 32'd0;
    res_lo    = 32'd0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   {res_hi, res_lo} = {rem_s, quot_s};
      OP_DIVU:  {res_hi, res_lo} = {rem_u, quot_u};
      default:  res_write = 1'b0;
    endcase
    if ((op == OP_DIV || op == OP_DIVU) && div_zero) begin
`ifdef MDU_DIV0_KEEP_EN
      res_write = 1'b0;
`else
      res_hi = a_lat;
      res_lo = 32'hFFFF_FFFF;
`endif
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    op_next    = op;
    a_lat_next = a_lat;
    b_lat_next = b_lat;
    hi_next    = hi;
    lo_next    = lo;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (mdop)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_next    = mdop;
              a_lat_next = a;
              b_lat_next = b;
              count_next = (mdop == OP_MULT || mdop == OP_MULTU) ? 5'(MUL_CYCLES) : 5'(DIV_CYCLES);
              state_next = BUSY;
            end
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        count_next = count - 5'd1;
        if (count == 5'd1) begin
          state_next = IDLE;
          done_next  = 1'b1;
          if (res_write) begin
            hi_next = res_hi;
            lo_next = res_lo;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= 5'd0;
      op    <= 3'd0;
      a_lat <= 32'd0;
      b_lat <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      op    <= op_next;
      a_lat <= a_lat_next;
      b_lat <= b_lat_next;
      hi    <= hi_next;
      lo    <= lo_next;
      done  <= done_next;
    end
  end

  assign busy = (state == BUSY);

endmodule
